// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: port identifiers and default RAM geometry.
package ram_port_arbiter_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int RAM_AW = 12;
  localparam int RAM_DW = 8;

endpackage

// File: rtl/ram_port_arbiter_arb2_starve.sv
// Two-way arbiter: round robin, or fixed A priority with a bounded-loss guard for B.
module arb2_starve
  import ram_port_arbiter_pkg::*;
#(
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic eligible_a,
  input  logic eligible_b,
  output logic grant,
  output logic grant_valid
);

  localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic          last_grant;
  logic [CW-1:0] starve_cnt;

  always_comb begin
    grant_valid = eligible_a | eligible_b;
    grant       = PORT_A;
    if (eligible_a && eligible_b) begin
      if (RR_MODE != 0) begin
        grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
      end else begin
        grant = (starve_cnt == STARVE_LIM) ? PORT_B : PORT_A;
      end
    end else if (eligible_b) begin
      grant = PORT_B;
    end
  end

  // Loss counter saturates at the limit so B is forced through exactly once per run of losses
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= PORT_B;
      starve_cnt <= '0;
    end else begin
      if (grant_valid) begin
        last_grant <= grant;
      end
      if (grant_valid && grant == PORT_B) begin
        starve_cnt <= '0;
      end else if (eligible_b && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between the Z80 bus (A) and a DMA/video engine (B).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW         = RAM_AW,
  parameter int DW         = RAM_DW,
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_wait_n,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  logic          elig_a, elig_b;
  logic          grant, grant_valid;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          vld_p1;
  logic          rd_port_p1;

  // A port whose ack is showing is still holding the request it was just served for
  assign elig_a = a_req && !a_ack;
  assign elig_b = b_req && !b_ack;

  arb2_starve #(
    .RR_MODE   (RR_MODE),
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .eligible_a (elig_a),
    .eligible_b (elig_b),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  assign sel_we    = (grant == PORT_B) ? b_we    : a_we;
  assign sel_addr  = (grant == PORT_B) ? b_addr  : a_addr;
  assign sel_wdata = (grant == PORT_B) ? b_wdata : a_wdata;

  // Stage p0 -> p1: command issue to RAM, ack, and read tag
  always_ff @(posedge clock) begin
    if (reset) begin
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      vld_p1    <= 1'b0;
    end else begin
      a_ack  <= grant_valid && (grant == PORT_A);
      b_ack  <= grant_valid && (grant == PORT_B);
      ram_we <= grant_valid && sel_we;
      if (grant_valid) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      vld_p1 <= grant_valid && !sel_we;
    end
  end

  always_ff @(posedge clock) begin
    rd_port_p1 <= grant;
  end

  // Stage p1 -> p2: RAM data returns, steered by the tag
  always_ff @(posedge clock) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= vld_p1 && (rd_port_p1 == PORT_A);
      b_rvalid <= vld_p1 && (rd_port_p1 == PORT_B);
    end
  end

  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;
  assign a_wait_n = !(a_req && !a_ack);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: fixed-priority and round-robin instances against a transaction-level model.
module tb_ram_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
  } cmd_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       a_req [2], a_we [2], b_req [2], b_we [2];
  logic [11:0] a_addr [2], b_addr [2], ram_addr [2];
  logic [7:0] a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
  logic [7:0] ram_wdata [2], ram_q [2];
  logic       a_ack [2], b_ack [2], a_rvalid [2], b_rvalid [2], a_wait_n [2], ram_we [2];

  logic [7:0] ram_mem [2][4096];
  logic       pl_we;
  logic [11:0] pl_addr;
  logic [7:0] pl_data;

  cmd_t qa [2][$];
  cmd_t qb [2][$];
  cmd_t held_a [2], held_b [2];

  logic [7:0] mem_m [2][4096];
  logic       ack_a_m [2], ack_b_m [2], pend_a_m [2], pend_b_m [2], rv_a_m [2], rv_b_m [2], we_m [2];
  logic [7:0] pend_d_m [2], rd_m [2], wd_m [2];
  logic [11:0] addr_m [2];
  int         last_m [2], starve_m [2];

  logic       o_aack [2], o_back [2], o_arv [2], o_brv [2], o_awn [2], o_rwe [2];
  logic [7:0] o_ard [2], o_brd [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(.AW(12), .DW(8), .RR_MODE(0), .STARVE_MAX(3)) dut0 (
    .clock(clock), .reset(reset),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]), .a_wait_n(a_wait_n[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]), .ram_q(ram_q[0])
  );

  ram_port_arbiter #(.AW(12), .DW(8), .RR_MODE(1), .STARVE_MAX(3)) dut1 (
    .clock(clock), .reset(reset),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]), .a_wait_n(a_wait_n[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]), .ram_q(ram_q[1])
  );

  // Behavioural synchronous RAMs, one per instance, with a bench preload port
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (pl_we) ram_mem[d][pl_addr] <= pl_data;
      else if (ram_we[d]) ram_mem[d][ram_addr[d]] <= ram_wdata[d];
      ram_q[d] <= ram_mem[d][ram_addr[d]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ack_a_m[d] = 0; ack_b_m[d] = 0; pend_a_m[d] = 0; pend_b_m[d] = 0;
      rv_a_m[d] = 0; rv_b_m[d] = 0; we_m[d] = 0; addr_m[d] = '0; wd_m[d] = '0;
      last_m[d] = 1; starve_m[d] = 0;
    end
  endtask

  // One clock cycle: present requests, check outputs at the falling edge, advance the model
  task automatic step();
    cmd_t c;
    logic ea, eb, wa, wb;
    for (int d = 0; d < 2; d++) begin
      if (ack_a_m[d]) begin
        a_req[d] = 1; a_we[d] = held_a[d].we; a_addr[d] = held_a[d].addr; a_wdata[d] = held_a[d].data;
      end else if (qa[d].size() > 0) begin
        a_req[d] = 1; a_we[d] = qa[d][0].we; a_addr[d] = qa[d][0].addr; a_wdata[d] = qa[d][0].data;
      end else a_req[d] = 0;
      if (ack_b_m[d]) begin
        b_req[d] = 1; b_we[d] = held_b[d].we; b_addr[d] = held_b[d].addr; b_wdata[d] = held_b[d].data;
      end else if (qb[d].size() > 0) begin
        b_req[d] = 1; b_we[d] = qb[d][0].we; b_addr[d] = qb[d][0].addr; b_wdata[d] = qb[d][0].data;
      end else b_req[d] = 0;
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_a_ack", d), 32'(a_ack[d]), 32'(ack_a_m[d]));
      chk($sformatf("d%0d_b_ack", d), 32'(b_ack[d]), 32'(ack_b_m[d]));
      chk($sformatf("d%0d_a_rvalid", d), 32'(a_rvalid[d]), 32'(rv_a_m[d]));
      chk($sformatf("d%0d_b_rvalid", d), 32'(b_rvalid[d]), 32'(rv_b_m[d]));
      if (rv_a_m[d]) chk($sformatf("d%0d_a_rdata", d), 32'(a_rdata[d]), 32'(rd_m[d]));
      if (rv_b_m[d]) chk($sformatf("d%0d_b_rdata", d), 32'(b_rdata[d]), 32'(rd_m[d]));
      chk($sformatf("d%0d_a_wait_n", d), 32'(a_wait_n[d]), 32'(!(a_req[d] && !ack_a_m[d])));
      chk($sformatf("d%0d_ram_we", d), 32'(ram_we[d]), 32'(we_m[d]));
      chk($sformatf("d%0d_ram_addr", d), 32'(ram_addr[d]), 32'(addr_m[d]));
      chk($sformatf("d%0d_ram_wdata", d), 32'(ram_wdata[d]), 32'(wd_m[d]));
      o_aack[d] = a_ack[d]; o_back[d] = b_ack[d]; o_arv[d] = a_rvalid[d]; o_brv[d] = b_rvalid[d];
      o_ard[d] = a_rdata[d]; o_brd[d] = b_rdata[d]; o_awn[d] = a_wait_n[d]; o_rwe[d] = ram_we[d];
    end
    if (reset) model_reset();
    else begin
      for (int d = 0; d < 2; d++) begin
        ea = a_req[d] && !ack_a_m[d];
        eb = b_req[d] && !ack_b_m[d];
        if (ea && eb) begin
          wb = (d == 1) ? (last_m[d] == 0) : (starve_m[d] == 3);
          wa = !wb;
        end else begin
          wa = ea; wb = eb;
        end
        if (wb) starve_m[d] = 0;
        else if (eb && starve_m[d] < 3) starve_m[d]++;
        if (wa || wb) last_m[d] = wb ? 1 : 0;
        rv_a_m[d] = pend_a_m[d]; rv_b_m[d] = pend_b_m[d]; rd_m[d] = pend_d_m[d];
        ack_a_m[d] = wa; ack_b_m[d] = wb;
        pend_a_m[d] = 0; pend_b_m[d] = 0; we_m[d] = 0;
        if (wa || wb) begin
          if (wa) begin c = qa[d][0]; held_a[d] = c; void'(qa[d].pop_front()); end
          else begin c = qb[d][0]; held_b[d] = c; void'(qb[d].pop_front()); end
          addr_m[d] = c.addr; wd_m[d] = c.data; we_m[d] = c.we;
          if (c.we) mem_m[d][c.addr] = c.data;
          else begin
            pend_d_m[d] = mem_m[d][c.addr];
            pend_a_m[d] = wa; pend_b_m[d] = wb;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push(input int d, input bit port_b, input logic we, input logic [11:0] addr, input logic [7:0] data);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data;
    if (port_b) qb[d].push_back(c);
    else qa[d].push_back(c);
  endtask

  task automatic preload(input logic [11:0] addr, input logic [7:0] data);
    pl_we = 1; pl_addr = addr; pl_data = data;
    mem_m[0][addr] = data; mem_m[1][addr] = data;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int wlow, brv_cnt, ak, bk;
    int seq [2][20];
    logic [7:0] got;
    reset = 1; pl_we = 0; pl_addr = '0; pl_data = '0;
    for (int d = 0; d < 2; d++) begin
      a_req[d] = 0; a_we[d] = 0; a_addr[d] = '0; a_wdata[d] = '0;
      b_req[d] = 0; b_we[d] = 0; b_addr[d] = '0; b_wdata[d] = '0;
    end
    model_reset();
    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) preload(12'(i), 8'(8'h30 + i));
    preload(12'h123, 8'h5A);
    preload(12'h010, 8'h11);
    preload(12'h020, 8'h22);
    preload(12'hFFF, 8'h00);
    pl_we = 0;
    step();
    reset = 0;

    // A-only read
    push(0, 0, 0, 12'h123, 8'h00);
    wlow = 0;
    step(); wlow += !o_awn[0]; chk("aonly_ack_c0", 32'(o_aack[0]), 0);
    step(); wlow += !o_awn[0]; chk("aonly_ack_c1", 32'(o_aack[0]), 1);
    step(); wlow += !o_awn[0]; chk("aonly_rvalid_c2", 32'(o_arv[0]), 1); chk("aonly_rdata", 32'(o_ard[0]), 32'h5A);
    chk("aonly_wait_cycles", 32'(wlow), 1);

    // Both ports request continuously on both instances
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        push(d, 0, 0, 12'(i), 8'h00);
        push(d, 1, 0, 12'(8 + i), 8'h00);
      end
    for (int k = 0; k < 20; k++) begin
      step();
      for (int d = 0; d < 2; d++) seq[d][k] = (o_aack[d] ? 1 : 0) + (o_back[d] ? 2 : 0);
    end
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 18; k++)
        chk($sformatf("d%0d_collide_ack_k%0d", d, k), 32'(seq[d][k]),
            (k == 0 || k == 17) ? 0 : ((k % 2 == 1) ? 1 : 2));

    // B writes 0xC3 to 0xFFF, then A reads it back
    brv_cnt = 0; got = '0;
    push(0, 1, 1, 12'hFFF, 8'hC3);
    for (int k = 0; k < 3; k++) begin step(); brv_cnt += o_brv[0]; end
    push(0, 0, 0, 12'hFFF, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(); brv_cnt += o_brv[0];
      if (o_arv[0]) got = o_ard[0];
    end
    chk("wr_rd_b_rvalid_count", 32'(brv_cnt), 0);
    chk("wr_rd_a_rdata", 32'(got), 32'hC3);

    // A read then B read one cycle later
    ak = -1; bk = -1;
    push(0, 0, 0, 12'h010, 8'h00);
    step();
    push(0, 1, 0, 12'h020, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step();
      if (o_arv[0]) begin ak = k; chk("b2b_a_rdata", 32'(o_ard[0]), 32'h11); end
      if (o_brv[0]) begin bk = k; chk("b2b_b_rdata", 32'(o_brd[0]), 32'h22); end
    end
    chk("b2b_a_rvalid_cycle", 32'(ak), 1);
    chk("b2b_b_rvalid_cycle", 32'(bk), 2);

    // Reset right after a write ack, with a B read in flight
    push(0, 0, 1, 12'h005, 8'h77);
    step();
    push(0, 1, 0, 12'h003, 8'h00);
    step(); chk("rst_a_ack_before", 32'(o_aack[0]), 1);
    reset = 1;
    step(); chk("rst_b_ack_before", 32'(o_back[0]), 1);
    reset = 0;
    push(0, 0, 0, 12'h007, 8'h00);
    push(0, 1, 0, 12'h008, 8'h00);
    step();
    chk("rst_no_b_rvalid", 32'(o_brv[0]), 0);
    chk("rst_no_a_rvalid", 32'(o_arv[0]), 0);
    chk("rst_ram_we", 32'(o_rwe[0]), 0);
    step();
    chk("rst_a_wins", 32'(o_aack[0]), 1);
    chk("rst_b_loses", 32'(o_back[0]), 0);
    for (int k = 0; k < 6; k++) step();

    // Randomised traffic on both instances
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (qa[d].size() == 0 && $urandom_range(0, 3) != 0)
          push(d, 0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 8'($urandom));
        if (qb[d].size() == 0 && $urandom_range(0, 3) != 0)
          push(d, 1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 8'($urandom));
      end
      step();
    end
    for (int k = 0; k < 20; k++) step();
    chk("drain_qa0", 32'(qa[0].size()), 0);
    chk("drain_qb1", 32'(qb[1].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
